// File: rtl/mips_cpu_bus_ctrl.sv
// MIPS core load/store bridge to an Avalon-MM master: lane steering, alignment check, load extension.
// Optional wait-state timeout abort is compiled in with `define MIPS_BUS_TIMEOUT_EN.
module mips_cpu_bus_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t     state;
  logic [1:0] size_p0;
  logic       signed_p0;
  logic [1:0] offset_p0;

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  // Parameter only matters when the timeout is built in.
  logic cfg_unused;
  assign cfg_unused = (WAIT_LIMIT != 0);
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_extend = {{24{sgn & b[7]}}, b};
      2'b01:   load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      size_p0    <= 2'b00;
      signed_p0  <= 1'b0;
      offset_p0  <= 2'b00;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= 4'b0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
`ifdef MIPS_BUS_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        // Capture stage: latch request, decide between bus cycle and immediate fault.
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          if (req_valid) begin
            size_p0   <= req_size;
            signed_p0 <= req_signed;
            offset_p0 <= req_addr[1:0];
            if (misaligned(req_size, req_addr[1:0])) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= BUS;
              read       <= ~req_write;
              write      <= req_write;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_mask(req_size, req_addr[1:0]);
              writedata  <= lane_data(req_size, req_wdata);
`ifdef MIPS_BUS_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end
          end
        end
        // Bus stage: hold strobes until the slave stops stalling.
        BUS: begin
          if (!waitrequest) begin
            state      <= RESP;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write ? 32'd0 : load_extend(size_p0, signed_p0, offset_p0, readdata);
          end
`ifdef MIPS_BUS_TIMEOUT_EN
          else if (wait_cnt == LIMIT_M1) begin
            state      <= RESP;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // Response stage: single-cycle strobe back to the core.
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Scoreboard bench for mips_cpu_bus_ctrl: directed loads/stores, faults, wait states, reset abort.
module tb_mips_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          bus;
  } exp_t;
  exp_t sb[$];

  // Bus-side expectations for the transaction currently in flight
  logic        exp_rd_strobe = 1'b0;
  logic        exp_wr_strobe = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wd = '0;
  int          bus_waits = 0;
  int          bus_cyc = 0;
  int          wcnt = 0;

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int LIMIT = 4;
`else
  localparam int LIMIT = 255;
`endif

  mips_cpu_bus_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Avalon slave model plus bus-side checks
  always @(negedge clk) begin
    if (read && write) chk("rd_wr_both", 32'(read & write), 32'd0);
    if (read || write) begin
      chk("bus_read", 32'(read), 32'(exp_rd_strobe));
      chk("bus_write", 32'(write), 32'(exp_wr_strobe));
      chk("bus_addr", address, exp_addr);
      chk("bus_be", 32'(byteenable), 32'(exp_be));
      if (write) chk("bus_wdata", writedata, exp_wd);
      bus_cyc++;
      if (wcnt < bus_waits) begin
        waitrequest = 1'b1;
        wcnt++;
      end else begin
        waitrequest = 1'b0;
      end
    end else begin
      if (byteenable != 4'b0000) chk("be_idle", 32'(byteenable), 32'd0);
      waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("bus_cycles", 32'(bus_cyc), 32'(e.bus));
      end
    end
  end

  // lat: edges from accept to response strobe (0 = fault, 1 + waits for a bus access)
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd_bus,
                       input int waits, input logic e_err, input logic [31:0] e_rdata,
                       input logic [3:0] e_be, input logic [31:0] e_wd, input int lat,
                       input bit push, input bit release_rst);
    int n;
    int guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!req_ready && guard < 50);
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    bus_waits     = waits;
    readdata      = rd_bus;
    exp_rd_strobe = ~wr;
    exp_wr_strobe = wr;
    exp_addr      = {addr[31:2], 2'b00};
    exp_be        = e_be;
    exp_wd        = e_wd;
    bus_cyc       = 0;
    req_write     = wr;
    req_size      = sz;
    req_signed    = sgn;
    req_addr      = addr;
    req_wdata     = wdata;
    req_valid     = 1'b1;
    if (release_rst) reset = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    req_addr  = 32'hFFFF_FFFF;
    if (release_rst) chk("accept_after_reset", 32'({read, write}), 32'({~wr, wr}));
    if (push) sb.push_back('{err: e_err, rdata: e_rdata, cyc: n + lat, bus: lat});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({read, write, resp_valid, resp_err}), 32'd0);
    chk("rst_be", 32'(byteenable), 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;

    //    wr    sz     sgn  addr          wdata         readdata      w  err  rdata         be       wd            lat
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0,        1, 1, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_0080, 4'b1000, 32'h0,        1, 1, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'h0,        3, 1'b0, 32'h0,        4'b1100, 32'h1234_1234, 4, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        0, 1, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0,        32'h1234_8001, 0, 1'b0, 32'hFFFF_8001, 4'b0011, 32'h0,        1, 1, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_4001, 32'h0000_00A5, 32'h0,        1, 1'b0, 32'h0,        4'b0010, 32'hA5A5_A5A5, 2, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_5001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        0, 1, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_6000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        0, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_7002, 32'h0,        32'hBEEF_0000, 0, 1'b0, 32'h0000_BEEF, 4'b1100, 32'h0,        1, 1, 0);
    issue(1'b0, 2'b10, 1'b1, 32'h0000_8000, 32'h0,        32'h8000_0001, 0, 1'b0, 32'h8000_0001, 4'b1111, 32'h0,        1, 1, 0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,        2, 1'b0, 32'h0,        4'b1111, 32'hCAFE_F00D, 3, 1, 0);

    // Abort a stalled load with reset; no response may appear for it
    issue(1'b0, 2'b10, 1'b0, 32'h0000_A000, 32'h0, 32'h5555_5555, 1000, 1'b0, 32'h0, 4'b1111, 32'h0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    chk("pre_reset_read", 32'(read), 32'd1);
    reset = 1'b0;
    #1;
    chk("reset_read_drop", 32'(read), 32'd0);
    chk("reset_be", 32'(byteenable), 32'd0);
    chk("reset_addr", address, 32'd0);
    chk("reset_resp", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_B008, 32'h0, 32'h1122_3344, 0, 1'b0, 32'h1122_3344, 4'b1111, 32'h0, 1, 1, 1);

`ifdef MIPS_BUS_TIMEOUT_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_C000, 32'h0, 32'h7777_7777, 100, 1'b1, 32'h0, 4'b1111, 32'h0, LIMIT, 1, 0);
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
